mem_io_responder: RTL and testbench

Memory and I/O responder on the SLC-3 memory bus, at the opposite end from the CPU datapath. It takes read/write requests built from MAR/MDR, applies a fixed wait-state latency, and accesses an internal word-addressed RAM or the memory-mapped switch/hex-display port at 0xFFFF. On completion it returns read data for the datapath's MDR_In path and issues a one-cycle ready pulse.

---
 rtl/mem_io_responder_if.sv | 21 ++
 rtl/mem_io_responder.sv | 151 +++++++++++++++
 tb/tb_mem_io_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// Request/response bus between the SLC-3 datapath (master) and the memory/IO responder (slave).
// The request is a held level; ready is a one-cycle completion pulse.
interface mem_io_responder_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;

    modport master (
        output mem_rd, mem_wr, addr, wdata,
        input  rdata, ready, busy
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wdata,
        output rdata, ready, busy
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO responder for the SLC-3 bus: fixed wait states, then one access to the internal RAM
// or to the switch/hex port at IO_ADDR, followed by a single ready pulse.
module mem_io_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    mem_io_responder_if.slave  bus,
    input  logic [15:0]        sw,
    output logic [15:0]        hex_out
);

    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // ST_HOLD is the sub-phase of DONE that waits for a still-held request to drop.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic [15:0]       addr_r;
    logic [15:0]       wdata_r;
    logic              op_wr_r;
    logic [15:0]       rdata_r;
    logic              ready_r;
    logic              busy_r;
    logic [15:0]       hex_r;
    logic [15:0]       sw_meta_r;
    logic [15:0]       sw_sync_r;
    logic [15:0]       ram_r [0:DEPTH-1];
    logic [ADDR_W-1:0] ram_idx_s;
    logic              ram_we_s;
    logic              req_s;

    function automatic logic is_io(input logic [15:0] a);
        return (a == IO_ADDR);
    endfunction

    assign bus.rdata = rdata_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign hex_out   = hex_r;

    // RAM port decode; only the ACCESS cycle of a non-IO write touches the array.
    always_comb begin
        req_s     = bus.mem_rd | bus.mem_wr;
        ram_idx_s = addr_r[ADDR_W-1:0];
        if ((state_r == ST_ACCESS) && op_wr_r && !is_io(addr_r)) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_r <= 16'h0000;
            sw_sync_r <= 16'h0000;
        end else begin
            sw_meta_r <= sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // RAM write port (contents deliberately not reset).
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= wdata_r;
        end
    end

    // Request controller: accept, wait, access, complete; outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
            op_wr_r <= 1'b0;
            rdata_r <= 16'h0000;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            hex_r   <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (req_s) begin
                        addr_r  <= bus.addr;
                        wdata_r <= bus.wdata;
                        op_wr_r <= bus.mem_wr;
                        busy_r  <= 1'b1;
                        cnt_r   <= WAIT_LOAD;
                        state_r <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_r <= ST_DONE;
                    ready_r <= 1'b1;
                    if (op_wr_r) begin
                        if (is_io(addr_r)) begin
                            hex_r <= wdata_r;
                        end
                    end else if (is_io(addr_r)) begin
                        rdata_r <= sw_sync_r;
                    end else begin
                        rdata_r <= ram_r[ram_idx_s];
                    end
                end
                ST_DONE: begin
                    ready_r <= 1'b0;
                    if (req_s) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    ready_r <= 1'b0;
                    if (!req_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus random traffic against a
// transaction-level model (word array, hex register, last-read value).
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic [15:0] hex_out;
    int          total = 0;
    int          bad   = 0;

    localparam int LAT = 4;

    logic [15:0] ref_ram   [0:1023];
    bit          ref_valid [0:1023];
    logic [15:0] ref_hex;
    logic [15:0] ref_rdata;

    always #5 clk = ~clk;

    mem_io_responder_if bus_if ();

    mem_io_responder #(
        .ADDR_W      (10),
        .WAIT_CYCLES (2),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .sw      (sw),
        .hex_out (hex_out)
    );

    // Transaction-level effect of one completed request; returns the expected rdata afterwards.
    function automatic logic [15:0] model_op(input logic rd, input logic wr, input logic [15:0] a,
                                             input logic [15:0] d, input logic [15:0] swv);
        if (wr) begin
            if (a == 16'hFFFF) ref_hex = d;
            else begin
                ref_ram[a[9:0]]   = d;
                ref_valid[a[9:0]] = 1'b1;
            end
        end else if (rd) begin
            if (a == 16'hFFFF) ref_rdata = swv;
            else ref_rdata = ref_ram[a[9:0]];
        end
        return ref_rdata;
    endfunction

    // Drive one request, hold it `hold` cycles past ready, then drop it; no checking here.
    task automatic bus_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input int hold, input int sw_k, input logic [15:0] sw_new,
                          output int lat, output logic [15:0] rd_val, output int extra_rdy,
                          output int busy_drops, output logic busy_after);
        bus_if.mem_rd = rd;
        bus_if.mem_wr = wr;
        bus_if.addr   = a;
        bus_if.wdata  = d;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == sw_k) sw = sw_new;
            if (bus_if.ready) begin
                lat = k;
                break;
            end
        end
        rd_val     = bus_if.rdata;
        extra_rdy  = 0;
        busy_drops = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus_if.ready) extra_rdy++;
            if (!bus_if.busy) busy_drops++;
        end
        bus_if.mem_rd = 1'b0;
        bus_if.mem_wr = 1'b0;
        bus_if.addr   = $urandom;
        bus_if.wdata  = $urandom;
        @(negedge clk);
        busy_after = bus_if.busy;
        if (bus_if.ready) extra_rdy++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_if.mem_rd = 1'b0;
        bus_if.mem_wr = 1'b0;
        bus_if.addr   = 16'h0000;
        bus_if.wdata  = 16'h0000;
        sw            = 16'h0000;
        repeat (3) @(negedge clk);
        total++; if (bus_if.rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata: got %h want 0000", bus_if.rdata); end
        total++; if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus_if.ready); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus_if.busy); end
        total++; if (hex_out !== 16'h0000) begin bad++; $display("FAIL rst_hex: got %h want 0000", hex_out); end
        reset     = 1'b1;
        ref_rdata = 16'h0000;
        ref_hex   = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, er, bd; logic [15:0] rv, exp_v; logic ba;
        exp_v = model_op(1'b0, 1'b1, 16'h0010, 16'h1234, sw);
        bus_op(1'b0, 1'b1, 16'h0010, 16'h1234, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (lat !== LAT) begin bad++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
        total++; if (rv !== exp_v) begin bad++; $display("FAIL wr_rdata_kept: got %h want %h", rv, exp_v); end
        total++; if (er !== 0 || ba !== 1'b0) begin bad++; $display("FAIL wr_release: extra_ready=%0d busy=%b want 0/0", er, ba); end
        exp_v = model_op(1'b1, 1'b0, 16'h0010, 16'h0000, sw);
        bus_op(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (lat !== LAT) begin bad++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
        total++; if (rv !== exp_v) begin bad++; $display("FAIL rd_data: got %h want %h", rv, exp_v); end
    endtask

    task automatic test_io_read();
        int lat, er, bd; logic [15:0] rv, exp_v; logic ba;
        sw = 16'h00A5;
        repeat (3) @(negedge clk);
        // sw flips after the second wait edge; the synchronizer still presents the old value.
        exp_v = model_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5);
        bus_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 2, 16'h005A, lat, rv, er, bd, ba);
        total++; if (rv !== exp_v) begin bad++; $display("FAIL io_rd_sync: got %h want %h", rv, exp_v); end
        repeat (3) @(negedge clk);
        exp_v = model_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, sw);
        bus_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (rv !== exp_v) begin bad++; $display("FAIL io_rd_new: got %h want %h", rv, exp_v); end
    endtask

    task automatic test_io_write();
        int lat, er, bd; logic [15:0] rv, exp_v, seed; logic ba;
        seed  = 16'($urandom);
        exp_v = model_op(1'b0, 1'b1, 16'h03FF, seed, sw);
        bus_op(1'b0, 1'b1, 16'h03FF, seed, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        exp_v = model_op(1'b0, 1'b1, 16'hFFFF, 16'hBEEF, sw);
        bus_op(1'b0, 1'b1, 16'hFFFF, 16'hBEEF, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (hex_out !== ref_hex) begin bad++; $display("FAIL io_wr_hex: got %h want %h", hex_out, ref_hex); end
        total++; if (rv !== exp_v) begin bad++; $display("FAIL io_wr_rdata_kept: got %h want %h", rv, exp_v); end
        exp_v = model_op(1'b1, 1'b0, 16'h03FF, 16'h0000, sw);
        bus_op(1'b1, 1'b0, 16'h03FF, 16'h0000, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (rv !== exp_v) begin bad++; $display("FAIL io_wr_ram_untouched: got %h want %h", rv, exp_v); end
    endtask

    task automatic test_held();
        int lat, er, bd; logic [15:0] rv, exp_v; logic ba;
        exp_v = model_op(1'b1, 1'b0, 16'h0010, 16'h0000, sw);
        bus_op(1'b1, 1'b0, 16'h0010, 16'h0000, 10, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (lat !== LAT || rv !== exp_v) begin bad++; $display("FAIL held_rd: lat=%0d data=%h want %0d/%h", lat, rv, LAT, exp_v); end
        total++; if (er !== 0) begin bad++; $display("FAIL held_one_ready: extra pulses %0d want 0", er); end
        total++; if (bd !== 0) begin bad++; $display("FAIL held_busy: busy low %0d cycles want 0", bd); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL held_release: busy=%b want 0", ba); end
    endtask

    task automatic test_reset_abort();
        int lat, er, bd, pulses; logic [15:0] rv, exp_v; logic ba;
        exp_v = model_op(1'b0, 1'b1, 16'h0020, 16'h0A0A, sw);
        bus_op(1'b0, 1'b1, 16'h0020, 16'h0A0A, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        pulses = 0;
        bus_if.mem_wr = 1'b1;
        bus_if.addr   = 16'h0020;
        bus_if.wdata  = 16'h5555;
        repeat (2) begin @(negedge clk); if (bus_if.ready) pulses++; end
        reset = 1'b0;
        bus_if.mem_wr = 1'b0;
        @(negedge clk);
        total++; if (bus_if.rdata !== 16'h0000 || hex_out !== 16'h0000) begin bad++; $display("FAIL abort_outputs: rdata=%h hex=%h want 0000/0000", bus_if.rdata, hex_out); end
        total++; if (bus_if.busy !== 1'b0 || bus_if.ready !== 1'b0) begin bad++; $display("FAIL abort_flags: busy=%b ready=%b want 0/0", bus_if.busy, bus_if.ready); end
        reset     = 1'b1;
        ref_rdata = 16'h0000;
        ref_hex   = 16'h0000;
        repeat (6) begin @(negedge clk); if (bus_if.ready) pulses++; end
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses); end
        exp_v = model_op(1'b1, 1'b0, 16'h0020, 16'h0000, sw);
        bus_op(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (rv !== exp_v) begin bad++; $display("FAIL abort_ram_kept: got %h want %h", rv, exp_v); end
    endtask

    task automatic test_alias_prec();
        int lat, er, bd; logic [15:0] rv, exp_v; logic ba;
        exp_v = model_op(1'b0, 1'b1, 16'h0400, 16'h7777, sw);
        bus_op(1'b0, 1'b1, 16'h0400, 16'h7777, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        exp_v = model_op(1'b1, 1'b0, 16'h0000, 16'h0000, sw);
        bus_op(1'b1, 1'b0, 16'h0000, 16'h0000, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (rv !== exp_v) begin bad++; $display("FAIL alias_rd: got %h want %h", rv, exp_v); end
        exp_v = model_op(1'b0, 1'b1, 16'h0001, 16'h1111, sw);
        bus_op(1'b1, 1'b1, 16'h0001, 16'h1111, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (lat !== LAT || rv !== exp_v) begin bad++; $display("FAIL prec_wr: lat=%0d rdata=%h want %0d/%h", lat, rv, LAT, exp_v); end
        exp_v = model_op(1'b1, 1'b0, 16'h0001, 16'h0000, sw);
        bus_op(1'b1, 1'b0, 16'h0001, 16'h0000, 0, 0, 16'h0000, lat, rv, er, bd, ba);
        total++; if (rv !== exp_v) begin bad++; $display("FAIL prec_rd: got %h want %h", rv, exp_v); end
    endtask

    task automatic test_random();
        int lat, er, bd, hold; logic [15:0] rv, exp_v, a, d; logic ba, rd, wr;
        for (int n = 0; n < 40; n++) begin
            a = {4'($urandom_range(0, 3)), 2'b00, 10'($urandom_range(0, 15))};
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            d    = 16'($urandom);
            rd   = 1'($urandom);
            wr   = 1'($urandom);
            hold = $urandom_range(0, 3);
            if (!rd && !wr) rd = 1'b1;
            if (!wr && a != 16'hFFFF && !ref_valid[a[9:0]]) wr = 1'b1;
            exp_v = model_op(rd, wr, a, d, sw);
            bus_op(rd, wr, a, d, hold, 0, 16'h0000, lat, rv, er, bd, ba);
            total++;
            if (lat !== LAT || rv !== exp_v || hex_out !== ref_hex || er !== 0 || bd !== 0) begin
                bad++;
                $display("FAIL rand_%0d: lat=%0d rdata=%h hex=%h extra=%0d bdrop=%0d want %0d/%h/%h/0/0",
                         n, lat, rv, hex_out, er, bd, LAT, exp_v, ref_hex);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
        test_reset();
        test_write_read();
        test_io_read();
        test_io_write();
        test_held();
        test_reset_abort();
        test_alias_prec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
